// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl: FIFO-buffered issue control with RAW bubbles, retire delay line and counters; OPERAND_MASK_EN limits hazard compares to operands the func reads
module pipeline_issue_ctrl #(
  parameter int         DEPTH        = 4,
  parameter logic [3:0] SCRATCH_REG  = 4'hF,
  parameter logic [7:0] SCRATCH_ADDR = 8'hFF,
  parameter logic [3:0] BUBBLE_FUNC  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [7:0]  in_addr,
  input  logic        halt,
  output logic [3:0]  p_rs1,
  output logic [3:0]  p_rs2,
  output logic [3:0]  p_rd,
  output logic [3:0]  p_func,
  output logic [7:0]  p_addr,
  output logic        ret_valid,
  output logic [3:0]  ret_rd,
  output logic        stall,
  output logic        idle,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt,
  output logic        err_rd
);
  localparam int AW = $clog2(DEPTH);
  logic [23:0] mem [DEPTH];
  logic [23:0] head;
  logic [AW:0] wp, rp;
  logic        empty, full, push, use_a, use_b, hit_a, hit_b, hazard, issue, hstall;
  logic        v0, v1, v2;
  logic [3:0]  rd1, rd2;
  assign head     = mem[rp[AW-1:0]];
  assign empty    = wp == rp;
  assign full     = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign in_ready = !full;
  assign push     = in_valid && !full;
`ifdef OPERAND_MASK_EN
  assign use_a = head[11:8] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9};
  assign use_b = head[11:8] inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'hA};
`else
  assign use_a = 1'b1;
  assign use_b = 1'b1;
`endif
  // v0 tracks the instruction in p_*, v1 the one loaded the edge before
  assign hit_a  = (v0 && p_rd == head[23:20]) || (v1 && rd1 == head[23:20]);
  assign hit_b  = (v0 && p_rd == head[19:16]) || (v1 && rd1 == head[19:16]);
  assign hazard = (use_a && hit_a) || (use_b && hit_b);
  assign issue  = !empty && !halt && !hazard;
  assign hstall = !empty && !halt && hazard;
  assign idle   = empty && !v0 && !v1 && !v2 && !ret_valid;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      {p_rs1, p_rs2, p_rd, p_func, p_addr} <= {8'h00, SCRATCH_REG, BUBBLE_FUNC, SCRATCH_ADDR};
      {v0, v1, v2, ret_valid} <= '0;
      rd1       <= '0;
      rd2       <= '0;
      ret_rd    <= '0;
      stall     <= 1'b0;
      issue_cnt <= '0;
      stall_cnt <= '0;
      err_rd    <= 1'b0;
    end else begin
      wp        <= wp + (AW+1)'(push);
      rp        <= rp + (AW+1)'(issue);
      {p_rs1, p_rs2, p_rd, p_func, p_addr} <= issue ? head : {8'h00, SCRATCH_REG, BUBBLE_FUNC, SCRATCH_ADDR};
      v0        <= issue;
      v1        <= v0;
      rd1       <= p_rd;
      v2        <= v1;
      rd2       <= rd1;
      ret_valid <= v2;
      ret_rd    <= rd2;
      stall     <= hstall;
      issue_cnt <= issue_cnt + 16'(issue && issue_cnt != 16'hFFFF);
      stall_cnt <= stall_cnt + 16'(hstall && stall_cnt != 16'hFFFF);
      err_rd    <= err_rd || (push && in_rd == SCRATCH_REG);
    end
  end
endmodule
